// File: rtl/sys_tx_fifo.sv
// sys_tx_fifo: first-word-fall-through byte FIFO buffering the controller TX stream for the serial transmitter
module sys_tx_fifo #(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH = 8,
   parameter int PTR_W = $clog2(DEPTH)
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic [DATA_WIDTH-1:0] WR_DATA,
   input  logic                  WR_INC,
   output logic                  FULL,
   input  logic                  RD_INC,
   output logic [DATA_WIDTH-1:0] RD_DATA,
   output logic                  EMPTY,
   output logic [PTR_W:0]        COUNT,
   output logic                  OVERFLOW,
   output logic                  UNDERFLOW
);
   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [PTR_W:0] wr_ptr, rd_ptr;
   logic do_wr, do_rd;
   // flags come only from registered pointers so FULL is stable while the controller decides
   assign EMPTY = wr_ptr == rd_ptr;
   assign FULL = wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0] && wr_ptr[PTR_W] != rd_ptr[PTR_W];
   assign COUNT = wr_ptr - rd_ptr;
   assign RD_DATA = mem[rd_ptr[PTR_W-1:0]];
   assign do_wr = WR_INC && !FULL;
   assign do_rd = RD_INC && !EMPTY;
   always_ff @(posedge CLK) begin
      if (RST) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         OVERFLOW <= 1'b0;
         UNDERFLOW <= 1'b0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         if (do_wr) begin
            mem[wr_ptr[PTR_W-1:0]] <= WR_DATA;
            wr_ptr <= wr_ptr + (PTR_W+1)'(1);
         end
         if (do_rd) rd_ptr <= rd_ptr + (PTR_W+1)'(1);
         if (WR_INC && FULL) OVERFLOW <= 1'b1;
         if (RD_INC && EMPTY) UNDERFLOW <= 1'b1;
      end
   end
endmodule

// File: tb/tb_sys_tx_fifo.sv
// tb_sys_tx_fifo: directed and random checks of sys_tx_fifo against a queue model
module tb_sys_tx_fifo;
   localparam int D = 8;
   logic CLK = 1'b0;
   logic RST, WR_INC, RD_INC, FULL, EMPTY, OVERFLOW, UNDERFLOW;
   logic [7:0] WR_DATA, RD_DATA;
   logic [3:0] COUNT;
   int total = 0, bad = 0;
   logic [7:0] q[$];
   bit ovf = 0, unf = 0, zero_head = 1;

   sys_tx_fifo #(.DATA_WIDTH(8), .DEPTH(D)) dut (
      .CLK(CLK), .RST(RST), .WR_DATA(WR_DATA), .WR_INC(WR_INC), .FULL(FULL),
      .RD_INC(RD_INC), .RD_DATA(RD_DATA), .EMPTY(EMPTY), .COUNT(COUNT),
      .OVERFLOW(OVERFLOW), .UNDERFLOW(UNDERFLOW)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   task automatic step(input string tag, input bit r, input bit w, input logic [7:0] d, input bit p);
      bit f, e;
      RST = r; WR_INC = w; WR_DATA = d; RD_INC = p;
      @(posedge CLK);
      f = q.size() == D;
      e = q.size() == 0;
      if (r) begin
         q.delete(); ovf = 0; unf = 0; zero_head = 1;
      end else begin
         if (w && f) ovf = 1;
         if (p && e) unf = 1;
         if (p && !e) void'(q.pop_front());
         if (w && !f) begin q.push_back(d); zero_head = 0; end
      end
      #1;
      check({tag, ".count"}, 32'(COUNT), q.size());
      check({tag, ".empty"}, 32'(EMPTY), 32'(q.size() == 0));
      check({tag, ".full"}, 32'(FULL), 32'(q.size() == D));
      check({tag, ".ovf"}, 32'(OVERFLOW), 32'(ovf));
      check({tag, ".unf"}, 32'(UNDERFLOW), 32'(unf));
      if (q.size() != 0) check({tag, ".head"}, 32'(RD_DATA), 32'(q[0]));
      else if (zero_head) check({tag, ".head0"}, 32'(RD_DATA), 0);
   endtask

   initial begin
      RST = 1; WR_INC = 0; RD_INC = 0; WR_DATA = 0;
      step("rst", 1, 1, 8'h5a, 0);
      step("rst", 1, 1, 8'h5a, 0);
      for (int i = 0; i < D; i++) step("fill", 0, 1, 8'(8'h10 + i), 0);
      step("ovf", 0, 1, 8'hee, 0);
      for (int i = 0; i < D; i++) step("drain", 0, 0, 8'h00, 1);
      step("unf", 0, 0, 8'h00, 1);
      step("both_empty", 0, 1, 8'h3c, 1);
      for (int i = 0; i < D - 1; i++) step("refill", 0, 1, 8'(8'h40 + i), 0);
      step("both_full", 0, 1, 8'h99, 1);
      for (int i = 0; i < D - 1; i++) step("drain2", 0, 0, 8'h00, 1);
      step("wrap", 0, 1, 8'(8'h80), 0);
      step("wrap", 0, 1, 8'(8'h81), 0);
      for (int i = 0; i < 18; i++) step("wrap", 0, 1, 8'($urandom), 1);
      step("wrap_end", 0, 0, 8'h00, 1);
      step("wrap_end", 0, 0, 8'h00, 1);
      step("alu_lo", 0, 1, 8'h34, 0);
      step("alu_hi", 0, 1, 8'h12, 0);
      step("rst_mid", 1, 1, 8'h77, 1);
      step("post_rst", 0, 1, 8'ha5, 0);
      step("post_rst_pop", 0, 0, 8'h00, 1);
      for (int i = 0; i < 400; i++) begin
         bit ph;
         ph = ((i / 50) % 2) == 0;
         step("rand", $urandom_range(0, 79) == 0, $urandom_range(0, 3) < (ph ? 3 : 1),
              8'($urandom), $urandom_range(0, 3) < (ph ? 1 : 3));
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
